// File: rtl/ncpu32k_ie_wb_buf_pkg.sv
// Shared constants for the IEU writeback buffer: datapath widths, LU opcode bit
// indices and the skid-buffer state encoding.
package ncpu32k_ie_wb_buf_pkg;

  localparam int unsigned NCPU_DW      = 32;
  localparam int unsigned NCPU_RAW     = 5;
  localparam int unsigned NCPU_LU_IOPW = 6;

  // Bit positions inside the one-hot LU opcode bus
  localparam int unsigned NCPU_LU_AND = 0;
  localparam int unsigned NCPU_LU_OR  = 1;
  localparam int unsigned NCPU_LU_XOR = 2;
  localparam int unsigned NCPU_LU_LSL = 3;
  localparam int unsigned NCPU_LU_LSR = 4;
  localparam int unsigned NCPU_LU_ASR = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_buf_state_e;

endpackage

// File: rtl/ncpu32k_ie_wb_buf_if.sv
// IEU-to-writeback bus: LU/AU results and destination tag in, registered result
// out. master = producer/consumer environment, slave = the buffer.
interface ncpu32k_ie_wb_buf_if
  import ncpu32k_ie_wb_buf_pkg::*;
#(
  parameter int unsigned DW      = NCPU_DW,
  parameter int unsigned RAW     = NCPU_RAW,
  parameter int unsigned LU_IOPW = NCPU_LU_IOPW
);

  logic               ieu_valid_in;
  logic               ieu_ready_in;
  logic [LU_IOPW-1:0] ieu_lu_opc_bus;
  logic               lu_op_shift;
  logic [DW-1:0]      lu_shift;
  logic [DW-1:0]      lu_and;
  logic [DW-1:0]      lu_or;
  logic [DW-1:0]      lu_xor;
  logic [DW-1:0]      au_result;
  logic [RAW-1:0]     ieu_rd_addr;
  logic               ieu_rd_we;
  logic               wb_valid;
  logic               wb_ready;
  logic [DW-1:0]      wb_dat;
  logic [RAW-1:0]     wb_rd_addr;
  logic               wb_rd_we;

  modport master (
    output ieu_valid_in, ieu_lu_opc_bus, lu_op_shift, lu_shift, lu_and, lu_or,
           lu_xor, au_result, ieu_rd_addr, ieu_rd_we, wb_ready,
    input  ieu_ready_in, wb_valid, wb_dat, wb_rd_addr, wb_rd_we
  );

  modport slave (
    input  ieu_valid_in, ieu_lu_opc_bus, lu_op_shift, lu_shift, lu_and, lu_or,
           lu_xor, au_result, ieu_rd_addr, ieu_rd_we, wb_ready,
    output ieu_ready_in, wb_valid, wb_dat, wb_rd_addr, wb_rd_we
  );

endinterface

// File: rtl/ncpu32k_ie_res_sel.sv
// Combinational AND-OR result mux over LU and AU results. Non-one-hot opcodes
// yield the OR of all selected terms.
module ncpu32k_ie_res_sel
  import ncpu32k_ie_wb_buf_pkg::*;
#(
  parameter int unsigned DW      = NCPU_DW,
  parameter int unsigned LU_IOPW = NCPU_LU_IOPW
) (
  input  logic [LU_IOPW-1:0] lu_opc_bus,
  input  logic               lu_op_shift,
  input  logic [DW-1:0]      lu_shift,
  input  logic [DW-1:0]      lu_and,
  input  logic [DW-1:0]      lu_or,
  input  logic [DW-1:0]      lu_xor,
  input  logic [DW-1:0]      au_result,
  output logic [DW-1:0]      res_c
);

  logic au_sel_c;

  always_comb begin
    au_sel_c = ~(|lu_opc_bus);
    res_c    = ({DW{lu_op_shift}}             & lu_shift)
             | ({DW{lu_opc_bus[NCPU_LU_AND]}} & lu_and)
             | ({DW{lu_opc_bus[NCPU_LU_OR]}}  & lu_or)
             | ({DW{lu_opc_bus[NCPU_LU_XOR]}} & lu_xor)
             | ({DW{au_sel_c}}                & au_result);
  end

endmodule

// File: rtl/ncpu32k_ie_wb_buf.sv
// IEU result buffer: selects the LU/AU result and presents it to writeback.
// NCPU_IE_WB_SKID_EN adds a skid entry so ieu_ready_in is registered.
module ncpu32k_ie_wb_buf
  import ncpu32k_ie_wb_buf_pkg::*;
#(
  parameter int unsigned DW      = NCPU_DW,
  parameter int unsigned RAW     = NCPU_RAW,
  parameter int unsigned LU_IOPW = NCPU_LU_IOPW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  ncpu32k_ie_wb_buf_if.slave   bus
);

  logic [DW-1:0] res_c;
  logic          accept_c;
  logic          pop_c;

  ncpu32k_ie_res_sel #(
    .DW      (DW),
    .LU_IOPW (LU_IOPW)
  ) u_res_sel (
    .lu_opc_bus  (bus.ieu_lu_opc_bus),
    .lu_op_shift (bus.lu_op_shift),
    .lu_shift    (bus.lu_shift),
    .lu_and      (bus.lu_and),
    .lu_or       (bus.lu_or),
    .lu_xor      (bus.lu_xor),
    .au_result   (bus.au_result),
    .res_c       (res_c)
  );

  // flush wins over accept; a flushed accept is simply dropped
  assign accept_c = bus.ieu_valid_in & bus.ieu_ready_in & ~flush;
  assign pop_c    = bus.wb_valid & bus.wb_ready;

`ifdef NCPU_IE_WB_SKID_EN

  wb_buf_state_e  state;
  logic           skid_valid;
  logic [DW-1:0]  skid_dat;
  logic [RAW-1:0] skid_rd_addr;
  logic           skid_rd_we;

  // Output register plus one skid entry; ready tracks ~skid_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= EMPTY;
      bus.wb_valid     <= 1'b0;
      bus.wb_dat       <= '0;
      bus.wb_rd_addr   <= '0;
      bus.wb_rd_we     <= 1'b0;
      skid_valid       <= 1'b0;
      skid_dat         <= '0;
      skid_rd_addr     <= '0;
      skid_rd_we       <= 1'b0;
      bus.ieu_ready_in <= 1'b1;
    end else if (flush) begin
      state            <= EMPTY;
      bus.wb_valid     <= 1'b0;
      skid_valid       <= 1'b0;
      bus.ieu_ready_in <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            bus.wb_dat     <= res_c;
            bus.wb_rd_addr <= RAW'(bus.ieu_rd_addr);
            bus.wb_rd_we   <= bus.ieu_rd_we;
            bus.wb_valid   <= 1'b1;
            state          <= ONE;
          end
        end
        ONE: begin
          if (accept_c && !pop_c) begin
            skid_dat         <= res_c;
            skid_rd_addr     <= RAW'(bus.ieu_rd_addr);
            skid_rd_we       <= bus.ieu_rd_we;
            skid_valid       <= 1'b1;
            bus.ieu_ready_in <= 1'b0;
            state            <= FULL;
          end else if (pop_c && !accept_c) begin
            bus.wb_valid <= 1'b0;
            state        <= EMPTY;
          end else if (pop_c && accept_c) begin
            bus.wb_dat     <= res_c;
            bus.wb_rd_addr <= RAW'(bus.ieu_rd_addr);
            bus.wb_rd_we   <= bus.ieu_rd_we;
          end
        end
        FULL: begin
          if (pop_c) begin
            bus.wb_dat       <= skid_dat;
            bus.wb_rd_addr   <= skid_rd_addr;
            bus.wb_rd_we     <= skid_rd_we;
            skid_valid       <= 1'b0;
            bus.ieu_ready_in <= 1'b1;
            state            <= ONE;
          end
        end
        default: begin
          bus.wb_valid     <= 1'b0;
          skid_valid       <= 1'b0;
          bus.ieu_ready_in <= 1'b1;
          state            <= EMPTY;
        end
      endcase
    end
  end

`else

  // Single stage: a pop frees the register for a same-cycle accept
  assign bus.ieu_ready_in = ~bus.wb_valid | bus.wb_ready | flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid   <= 1'b0;
      bus.wb_dat     <= '0;
      bus.wb_rd_addr <= '0;
      bus.wb_rd_we   <= 1'b0;
    end else begin
      if (flush) begin
        bus.wb_valid <= 1'b0;
      end else if (accept_c) begin
        bus.wb_valid <= 1'b1;
      end else if (pop_c) begin
        bus.wb_valid <= 1'b0;
      end
      if (accept_c) begin
        bus.wb_dat     <= res_c;
        bus.wb_rd_addr <= RAW'(bus.ieu_rd_addr);
        bus.wb_rd_we   <= bus.ieu_rd_we;
      end
    end
  end

`endif

endmodule

// File: tb/tb_ncpu32k_ie_wb_buf.sv
// Randomized bench for ncpu32k_ie_wb_buf against a queue-based reference model.
module tb_ncpu32k_ie_wb_buf;
  import ncpu32k_ie_wb_buf_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned RAW = 5;
  localparam int unsigned OPW = 6;

  typedef struct packed {
    logic [DW-1:0]  dat;
    logic [RAW-1:0] rd;
    logic           we;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ncpu32k_ie_wb_buf_if #(.DW(DW), .RAW(RAW), .LU_IOPW(OPW)) bus ();

  ncpu32k_ie_wb_buf #(.DW(DW), .RAW(RAW), .LU_IOPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int    n_checks   = 0;
  int    n_errors   = 0;
  int    n_dut_pops = 0;
  item_t q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected selection from the operands currently driven
  function automatic logic [DW-1:0] ref_result();
    logic [OPW-1:0] m;
    logic [DW-1:0]  r;
    m = bus.ieu_lu_opc_bus;
    r = '0;
    if (m == '0) return bus.au_result;
    if (m[0]) r = r | bus.lu_and;
    if (m[1]) r = r | bus.lu_or;
    if (m[2]) r = r | bus.lu_xor;
    if (m[5:3] != 3'b000) r = r | bus.lu_shift;
    return r;
  endfunction

  function automatic logic [OPW-1:0] rand_mask();
    int unsigned k;
    logic [OPW-1:0] m;
    k = $urandom_range(0, 9);
    if (k == 0) m = '0;
    else if (k <= 6) m = OPW'(1) << (k - 1);
    else m = (OPW'(1) << $urandom_range(0, 5)) | (OPW'(1) << $urandom_range(0, 5));
    return m;
  endfunction

  task automatic drive(input bit v, input logic [OPW-1:0] mask, input logic [RAW-1:0] rd, input bit we);
    bus.ieu_valid_in   = v;
    bus.ieu_lu_opc_bus = mask;
    bus.lu_op_shift    = (mask[5:3] != 3'b000);
    bus.lu_shift       = $urandom();
    bus.lu_and         = $urandom();
    bus.lu_or          = $urandom();
    bus.lu_xor         = $urandom();
    bus.au_result      = $urandom();
    bus.ieu_rd_addr    = rd;
    bus.ieu_rd_we      = we;
  endtask

  // Check outputs mid-cycle, then advance model and DUT by one clock
  task automatic cycle(output bit acc);
    bit    exp_ready;
    bit    pop;
    item_t it;
    #4;
`ifdef NCPU_IE_WB_SKID_EN
    exp_ready = (q.size() < 2);
`else
    exp_ready = (q.size() == 0) || bus.wb_ready || flush;
`endif
    check("ieu_ready_in", 64'(bus.ieu_ready_in), 64'(exp_ready));
    check("wb_valid", 64'(bus.wb_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("wb_dat", 64'(bus.wb_dat), 64'(q[0].dat));
      check("wb_rd_addr", 64'(bus.wb_rd_addr), 64'(q[0].rd));
      check("wb_rd_we", 64'(bus.wb_rd_we), 64'(q[0].we));
    end
    if (bus.wb_valid && bus.wb_ready) n_dut_pops++;
    pop = (q.size() != 0) && bus.wb_ready;
    acc = bus.ieu_valid_in && exp_ready && !flush;
    it  = '{ref_result(), bus.ieu_rd_addr, bus.ieu_rd_we};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    #1;
  endtask

  task automatic drain();
    bit a;
    drive(1'b0, '0, '0, 1'b0);
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(a);
  endtask

  initial begin
    bit acc;
    int p0;
    drive(1'b0, '0, '0, 1'b0);
    bus.wb_ready = 1'b0;

    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("rst_wb_dat", 64'(bus.wb_dat), 64'(0));
    check("rst_wb_rd_addr", 64'(bus.wb_rd_addr), 64'(0));
    check("rst_wb_rd_we", 64'(bus.wb_rd_we), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 64'(bus.ieu_ready_in), 64'(1));

    // LU AND
    bus.wb_ready = 1'b1;
    drive(1'b1, OPW'(1) << NCPU_LU_AND, RAW'(3), 1'b1);
    bus.lu_and = 32'h00F0_000F;
    cycle(acc);
    drive(1'b0, '0, '0, 1'b0);
    check("and_valid", 64'(bus.wb_valid), 64'(1));
    check("and_dat", 64'(bus.wb_dat), 64'(32'h00F0_000F));
    check("and_rd", 64'(bus.wb_rd_addr), 64'(3));
    check("and_we", 64'(bus.wb_rd_we), 64'(1));

    // AU passthrough when no LU bit is set
    drive(1'b1, '0, RAW'(7), 1'b1);
    bus.au_result = 32'h1234_5678;
    cycle(acc);
    check("au_dat", 64'(bus.wb_dat), 64'(32'h1234_5678));
    drain();

    // Back-to-back shift then XOR with writeback stalled for 3 cycles
    bus.wb_ready = 1'b0;
    drive(1'b1, OPW'(1) << NCPU_LU_LSR, RAW'(1), 1'b1);
    bus.lu_shift = 32'h0000_0001;
    cycle(acc);
    drive(1'b1, OPW'(1) << NCPU_LU_XOR, RAW'(2), 1'b1);
    bus.lu_xor = 32'hAAAA_AAAA;
    acc = 1'b0;
    for (int k = 1; k < 20 && !acc; k++) begin
      if (k >= 3) bus.wb_ready = 1'b1;
      cycle(acc);
    end
    drain();

    // 8 back-to-back results, no bubbles
    p0 = n_dut_pops;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rand_mask(), RAW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      cycle(acc);
    end
    drive(1'b0, '0, '0, 1'b0);
    cycle(acc);
    check("burst_pops", 64'(n_dut_pops - p0), 64'(8));
    drain();

    // Flush with a held result and a same-cycle accept
    bus.wb_ready = 1'b0;
    drive(1'b1, OPW'(1) << NCPU_LU_AND, RAW'(4), 1'b1);
    cycle(acc);
    drive(1'b1, OPW'(1) << NCPU_LU_OR, RAW'(5), 1'b1);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("flush_valid", 64'(bus.wb_valid), 64'(0));
    check("flush_ready", 64'(bus.ieu_ready_in), 64'(1));
    drain();

    // Asynchronous reset mid-cycle with the buffer filled
    bus.wb_ready = 1'b0;
    drive(1'b1, '0, RAW'(9), 1'b1);
    cycle(acc);
    drive(1'b1, '0, RAW'(10), 1'b0);
    cycle(acc);
    drive(1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", 64'(bus.wb_valid), 64'(0));
    check("arst_wb_dat", 64'(bus.wb_dat), 64'(0));
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("arst_ready", 64'(bus.ieu_ready_in), 64'(1));
    drain();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_mask(),
            RAW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.wb_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      cycle(acc);
    end
    flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
